// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the BCD countdown timer.
//  DIGIT_W   : width of one BCD digit
//  BCD_MAX   : largest legal keypad digit, also the wrap value of units/minute digits
//  DSEC_WRAP : wrap value of the seconds-tens digit on borrow
//  state_t   : timer FSM states
package bcd_countdown_timer_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_MAX   = 4'd9;
  localparam logic [DIGIT_W-1:0] DSEC_WRAP = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // True for keypad codes 0..9.
  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Keypad-side and display-side signals of the countdown timer.
//  master : keypad decoder side (drives load/stop/bcd_input, reads status and digits)
//  slave  : the timer itself
interface bcd_countdown_timer_if #(
  parameter int unsigned MIN_DIGITS = 1
);

  logic                                               load;
  logic                                               stop;
  logic [bcd_countdown_timer_pkg::DIGIT_W-1:0]        bcd_input;
  logic                                               zero;
  logic                                               done;
  logic                                               running;
  logic [bcd_countdown_timer_pkg::DIGIT_W-1:0]        bcd_output_usec;
  logic [bcd_countdown_timer_pkg::DIGIT_W-1:0]        bcd_output_dsec;
  logic [bcd_countdown_timer_pkg::DIGIT_W*MIN_DIGITS-1:0] bcd_output_min;

  modport master (
    output load, stop, bcd_input,
    input  zero, done, running, bcd_output_usec, bcd_output_dsec, bcd_output_min
  );

  modport slave (
    input  load, stop, bcd_input,
    output zero, done, running, bcd_output_usec, bcd_output_dsec, bcd_output_min
  );

endinterface

// File: rtl/bcd_countdown_timer_digit.sv
// One BCD down-counting digit with parallel load.
//  clk, clear : clock and synchronous active-high reset
//  load_en    : take load_val (shift path), has priority over decrement
//  dec        : decrement enable for the whole chain (one-second tick)
//  borrow_in  : this digit must count down (all lower digits were 0)
//  borrow_out : borrow_in and this digit is 0; also serves as "digits so far are zero"
//  q          : digit value
module bcd_down_digit
  import bcd_countdown_timer_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] WRAP = BCD_MAX
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               load_en,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               dec,
  input  logic               borrow_in,
  output logic               borrow_out,
  output logic [DIGIT_W-1:0] q
);

  assign borrow_out = borrow_in && (q == '0);

  // Digit register: clear > load > decrement.
  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (load_en) begin
      q <= load_val;
    end else if (dec && borrow_in) begin
      q <= (q == '0) ? WRAP : q - DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Microwave countdown timer: keypad digits shift into MM..M:SS, a prescaler
// produces the one-second tick and the value counts down to zero.
//  clk   : rising-edge clock
//  clear : synchronous active-high reset, overrides everything
//  bus   : keypad inputs (load, stop, bcd_input) and status/digit outputs
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int unsigned MIN_DIGITS = 1,
  parameter int unsigned TICK_DIV   = 1
) (
  input  logic                  clk,
  input  logic                  clear,
  bcd_countdown_timer_if.slave  bus
);

  localparam int unsigned ND = MIN_DIGITS + 2;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // dig[0] = seconds units, dig[1] = seconds tens, dig[2..] = minutes.
  logic [DIGIT_W-1:0] dig [ND];
  // borrow[i] = all digits below i are zero; borrow[ND] = whole value zero.
  logic               borrow [ND+1];

  state_t        state;
  logic [PW-1:0] presc;
  logic          done_q;

  logic digit_ok;
  logic shift_en;
  logic tick;
  logic upper_zero;
  logic shift_zero;
  logic last_tick;

  assign borrow[0] = 1'b1;
  assign digit_ok  = is_bcd(bus.bcd_input);
  assign shift_en  = bus.load && digit_ok;
  assign tick      = (state == ST_RUN) && !bus.load && !bus.stop &&
                     (presc == PW'(TICK_DIV - 1));

  // Digit chain; each digit loads its lower neighbour on a shift.
  for (genvar i = 0; i < ND; i++) begin : g_dig
    localparam logic [DIGIT_W-1:0] WR = (i == 1) ? DSEC_WRAP : BCD_MAX;
    logic [DIGIT_W-1:0] lv;
    if (i == 0) begin : g_lsd
      assign lv = bus.bcd_input;
    end else begin : g_upper
      assign lv = dig[i-1];
    end
    bcd_down_digit #(.WRAP(WR)) u_digit (
      .clk        (clk),
      .clear      (clear),
      .load_en    (shift_en),
      .load_val   (lv),
      .dec        (tick),
      .borrow_in  (borrow[i]),
      .borrow_out (borrow[i+1]),
      .q          (dig[i])
    );
  end

  // Look-ahead: does this tick reach zero, does this shift produce zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int unsigned i = 1; i < ND; i++) begin
      if (dig[i] != '0) upper_zero = 1'b0;
    end
    shift_zero = (bus.bcd_input == '0);
    for (int unsigned i = 0; i < ND - 1; i++) begin
      if (dig[i] != '0) shift_zero = 1'b0;
    end
  end

  assign last_tick = upper_zero && (dig[0] == DIGIT_W'(1));

  // FSM, prescaler and done pulse: clear > load > stop > tick.
  always_ff @(posedge clk) begin
    if (clear) begin
      state  <= ST_IDLE;
      presc  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.load) begin
        // Invalid digits still resynchronise the prescaler.
        presc <= '0;
        if (digit_ok) state <= shift_zero ? ST_IDLE : ST_HOLD;
      end else if (state != ST_RUN) begin
        if (!bus.stop && !borrow[ND]) state <= ST_RUN;
      end else if (bus.stop) begin
        // Prescaler kept so a resumed second is not lengthened.
        state <= ST_HOLD;
      end else if (tick) begin
        presc <= '0;
        if (last_tick) begin
          done_q <= 1'b1;
          state  <= ST_IDLE;
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  assign bus.zero            = borrow[ND];
  assign bus.done            = done_q;
  assign bus.running         = (state == ST_RUN);
  assign bus.bcd_output_usec = dig[0];
  assign bus.bcd_output_dsec = dig[1];

  for (genvar j = 0; j < MIN_DIGITS; j++) begin : g_min
    assign bus.bcd_output_min[DIGIT_W*j +: DIGIT_W] = dig[j+2];
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: four configurations driven by shared stimulus,
// each compared every cycle against a seconds/minutes arithmetic model.
module tb_bcd_countdown_timer;

  localparam int NI = 4;
  localparam int MDV [NI] = '{1, 1, 2, 3};
  localparam int TDV [NI] = '{1, 4, 1, 3};

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       load = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] din = 4'd0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_countdown_timer_if #(.MIN_DIGITS(1)) if0 ();
  bcd_countdown_timer_if #(.MIN_DIGITS(1)) if1 ();
  bcd_countdown_timer_if #(.MIN_DIGITS(2)) if2 ();
  bcd_countdown_timer_if #(.MIN_DIGITS(3)) if3 ();

  assign if0.load = load; assign if0.stop = stop; assign if0.bcd_input = din;
  assign if1.load = load; assign if1.stop = stop; assign if1.bcd_input = din;
  assign if2.load = load; assign if2.stop = stop; assign if2.bcd_input = din;
  assign if3.load = load; assign if3.stop = stop; assign if3.bcd_input = din;

  bcd_countdown_timer #(.MIN_DIGITS(1), .TICK_DIV(1)) dut0 (.clk(clk), .clear(clear), .bus(if0.slave));
  bcd_countdown_timer #(.MIN_DIGITS(1), .TICK_DIV(4)) dut1 (.clk(clk), .clear(clear), .bus(if1.slave));
  bcd_countdown_timer #(.MIN_DIGITS(2), .TICK_DIV(1)) dut2 (.clk(clk), .clear(clear), .bus(if2.slave));
  bcd_countdown_timer #(.MIN_DIGITS(3), .TICK_DIV(3)) dut3 (.clk(clk), .clear(clear), .bus(if3.slave));

  // Reference model: minutes as an integer, seconds field as an integer 0..99.
  int m_min [NI];
  int m_sec [NI];
  int m_pre [NI];
  bit m_run [NI];
  bit m_done [NI];

  task automatic model_step(input int k);
    int n;
    int lim;
    m_done[k] = 1'b0;
    if (clear) begin
      m_min[k] = 0; m_sec[k] = 0; m_pre[k] = 0; m_run[k] = 1'b0;
    end else if (load) begin
      m_pre[k] = 0;
      if (din <= 4'd9) begin
        lim = 1;
        for (int i = 0; i < MDV[k] + 2; i++) lim = lim * 10;
        n = ((m_min[k] * 100 + m_sec[k]) * 10 + int'(din)) % lim;
        m_min[k] = n / 100;
        m_sec[k] = n % 100;
        m_run[k] = 1'b0;
      end
    end else if (!m_run[k]) begin
      if (!stop && (m_min[k] != 0 || m_sec[k] != 0)) m_run[k] = 1'b1;
    end else if (stop) begin
      m_run[k] = 1'b0;
    end else if (m_pre[k] == TDV[k] - 1) begin
      m_pre[k] = 0;
      if (m_sec[k] > 0) m_sec[k] = m_sec[k] - 1;
      else begin
        m_sec[k] = 59;
        m_min[k] = m_min[k] - 1;
      end
      if (m_min[k] == 0 && m_sec[k] == 0) begin
        m_done[k] = 1'b1;
        m_run[k]  = 1'b0;
      end
    end else begin
      m_pre[k] = m_pre[k] + 1;
    end
  endtask

  function automatic int to_bcd(input int v);
    int r = 0;
    int x = v;
    for (int i = 0; i < 3; i++) begin
      r = r | ((x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic get_act(input int k, output int u, output int ds, output int mn,
                         output int z, output int dn, output int r);
    case (k)
      0: begin u = int'(if0.bcd_output_usec); ds = int'(if0.bcd_output_dsec); mn = int'(if0.bcd_output_min);
               z = int'(if0.zero); dn = int'(if0.done); r = int'(if0.running); end
      1: begin u = int'(if1.bcd_output_usec); ds = int'(if1.bcd_output_dsec); mn = int'(if1.bcd_output_min);
               z = int'(if1.zero); dn = int'(if1.done); r = int'(if1.running); end
      2: begin u = int'(if2.bcd_output_usec); ds = int'(if2.bcd_output_dsec); mn = int'(if2.bcd_output_min);
               z = int'(if2.zero); dn = int'(if2.done); r = int'(if2.running); end
      default: begin u = int'(if3.bcd_output_usec); ds = int'(if3.bcd_output_dsec); mn = int'(if3.bcd_output_min);
               z = int'(if3.zero); dn = int'(if3.done); r = int'(if3.running); end
    endcase
  endtask

  task automatic check_models();
    int u, ds, mn, z, dn, r;
    for (int k = 0; k < NI; k++) begin
      get_act(k, u, ds, mn, z, dn, r);
      check($sformatf("i%0d usec", k), u, m_sec[k] % 10);
      check($sformatf("i%0d dsec", k), ds, m_sec[k] / 10);
      check($sformatf("i%0d min", k), mn, to_bcd(m_min[k]));
      check($sformatf("i%0d zero", k), z, int'(m_min[k] == 0 && m_sec[k] == 0));
      check($sformatf("i%0d done", k), dn, int'(m_done[k]));
      check($sformatf("i%0d running", k), r, int'(m_run[k]));
    end
  endtask

  // One clock: apply inputs, advance models at the edge, compare 1 ns later.
  task automatic cycle(input bit c, input bit l, input bit s, input logic [3:0] d);
    clear = c; load = l; stop = s; din = d;
    @(posedge clk);
    for (int k = 0; k < NI; k++) model_step(k);
    #1;
    check_models();
  endtask

  task automatic chk0(input string nm, input int u, input int ds, input int mn);
    check({nm, " usec"}, int'(if0.bcd_output_usec), u);
    check({nm, " dsec"}, int'(if0.bcd_output_dsec), ds);
    check({nm, " min"},  int'(if0.bcd_output_min), mn);
  endtask

  typedef struct {
    bit         c, l, s;
    logic [3:0] d;
    int         u, ds, mn;
    bit         z, dn, r;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int dn_cnt;

    // Instance 0 (1 minute digit, tick every cycle), hand-derived.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'd0, 0, 0, 0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 4'd1, 1, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 4'd3, 3, 1, 0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 4'd0, 0, 3, 1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 4'hC, 0, 3, 1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 4'd0, 0, 3, 1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 4'd0, 0, 3, 1, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 4'd0, 9, 2, 1, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 4'd0, 9, 2, 1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'd0, 9, 2, 1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 4'd0, 8, 2, 1, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].c, tbl[i].l, tbl[i].s, tbl[i].d);
      chk0($sformatf("tbl%0d", i), tbl[i].u, tbl[i].ds, tbl[i].mn);
      check($sformatf("tbl%0d zero", i), int'(if0.zero), int'(tbl[i].z));
      check($sformatf("tbl%0d done", i), int'(if0.done), int'(tbl[i].dn));
      check($sformatf("tbl%0d running", i), int'(if0.running), int'(tbl[i].r));
    end

    // 1:30 counts to zero in 90 ticks with a single done pulse.
    cycle(1, 0, 0, 4'd0);
    cycle(0, 1, 0, 4'd1); cycle(0, 1, 0, 4'd3); cycle(0, 1, 0, 4'd0);
    cycle(0, 0, 0, 4'd0);
    for (int t = 1; t <= 90; t++) begin
      cycle(0, 0, 0, 4'd0);
      if (t == 1)  chk0("t1 first tick", 9, 2, 1);
      if (t == 31) chk0("t1 31 ticks", 9, 5, 0);
      if (t == 89) check("t1 done early", int'(if0.done), 0);
    end
    chk0("t1 end", 0, 0, 0);
    check("t1 done", int'(if0.done), 1);
    check("t1 running", int'(if0.running), 0);
    cycle(0, 0, 0, 4'd0);
    check("t1 done width", int'(if0.done), 0);
    chk0("t1 held", 0, 0, 0);

    // 0:90 with non-normalised tens digit.
    cycle(1, 0, 0, 4'd0);
    cycle(0, 1, 0, 4'd9); cycle(0, 1, 0, 4'd0);
    cycle(0, 0, 0, 4'd0);
    dn_cnt = 0;
    for (int t = 1; t <= 100; t++) begin
      cycle(0, 0, 0, 4'd0);
      if (t == 1) chk0("t2 first tick", 9, 8, 0);
      if (if0.done) dn_cnt++;
    end
    check("t2 done count", dn_cnt, 1);
    check("t2 zero", int'(if0.zero), 1);
    check("t2 running", int'(if0.running), 0);

    // Prescaled pause/resume on instance 1 (TICK_DIV=4).
    cycle(1, 0, 0, 4'd0);
    cycle(0, 1, 0, 4'd5);
    cycle(0, 0, 0, 4'd0);
    for (int t = 1; t <= 6; t++) begin
      cycle(0, 0, 0, 4'd0);
      if (t == 3) check("t3 pre-tick", int'(if1.bcd_output_usec), 5);
      if (t == 4) check("t3 first tick", int'(if1.bcd_output_usec), 4);
    end
    for (int t = 0; t < 10; t++) cycle(0, 0, 1, 4'd0);
    check("t3 frozen", int'(if1.bcd_output_usec), 4);
    check("t3 paused running", int'(if1.running), 0);
    cycle(0, 0, 0, 4'd0);
    cycle(0, 0, 0, 4'd0);
    check("t3 resume pre-tick", int'(if1.bcd_output_usec), 4);
    cycle(0, 0, 0, 4'd0);
    check("t3 resume tick", int'(if1.bcd_output_usec), 3);

    // Invalid digit rejected; triple 7 overflows the minute digit.
    cycle(1, 0, 0, 4'd0);
    cycle(0, 1, 0, 4'd2);
    cycle(0, 1, 0, 4'hC);
    chk0("t4 invalid", 2, 0, 0);
    cycle(0, 1, 0, 4'd7); cycle(0, 1, 0, 4'd7); cycle(0, 1, 0, 4'd7);
    chk0("t4 777", 7, 7, 7);

    // Two-digit minute borrow on instance 2.
    cycle(1, 0, 0, 4'd0);
    cycle(0, 1, 0, 4'd1); cycle(0, 1, 0, 4'd0); cycle(0, 1, 0, 4'd0); cycle(0, 1, 0, 4'd0);
    check("t5 loaded min", int'(if2.bcd_output_min), 'h10);
    cycle(0, 0, 0, 4'd0);
    cycle(0, 0, 0, 4'd0);
    check("t5 min", int'(if2.bcd_output_min), 'h09);
    check("t5 dsec", int'(if2.bcd_output_dsec), 5);
    check("t5 usec", int'(if2.bcd_output_usec), 9);

    // Clear mid-run, then load on the final-tick cycle.
    cycle(1, 0, 0, 4'd0);
    cycle(0, 1, 0, 4'd4); cycle(0, 1, 0, 4'd3);
    cycle(0, 0, 0, 4'd0);
    cycle(0, 0, 0, 4'd0);
    chk0("t6 0:42", 2, 4, 0);
    cycle(1, 0, 0, 4'd0);
    chk0("t6 cleared", 0, 0, 0);
    check("t6 clr running", int'(if0.running), 0);
    check("t6 clr done", int'(if0.done), 0);
    cycle(0, 1, 0, 4'd1);
    cycle(0, 0, 0, 4'd0);
    cycle(0, 1, 0, 4'd6);
    chk0("t6 load wins", 6, 1, 0);
    check("t6 no done", int'(if0.done), 0);
    cycle(0, 0, 1, 4'd0);
    check("t6 no done later", int'(if0.done), 0);

    // Random traffic against the model on all four configurations.
    cycle(1, 0, 0, 4'd0);
    for (int t = 0; t < 3000; t++) begin
      cycle(($urandom % 100) == 0, ($urandom % 8) == 0, ($urandom % 6) == 0,
            4'($urandom % 16));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
